// File: rtl/ram_burst_reader_pkg.sv
// Shared types and constants for the RAM burst reader and its read FIFO.
package ram_burst_reader_pkg;

  // Burst engine control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Two slots are enough to absorb the one-cycle RAM latency at full rate.
  localparam int FIFO_DEPTH = 2;

  // Width of the FIFO occupancy counter (holds 0..FIFO_DEPTH).
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  // Default RAM word width; a FIFO entry carries the data word plus the last tag.
  localparam int DEFAULT_DATA_WIDTH = 8;

  // FIFO entry width for a given data width: data bits plus one last bit.
  function automatic int fifo_entry_width(input int data_width);
    return data_width + 1;
  endfunction

  localparam int FIFO_ENTRY_WIDTH = fifo_entry_width(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/ram_burst_reader_fifo.sv
// ram_rd_fifo: two-entry synchronous FIFO buffering RAM read data for the
// stream output. Simultaneous push and pop are accepted when full.
module ram_rd_fifo
  import ram_burst_reader_pkg::*;
#(
  parameter int WIDTH = FIFO_ENTRY_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0]      slots_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  full;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head  = slots_q[rd_ptr_q];
  assign count = count_q;

  // Storage, pointers and occupancy, all updated on the same edge.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is reset on purpose so the stream data output reads 0 after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        slots_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        slots_q[wr_ptr_q] <= push_data;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: issues one RAM read per allowed cycle for a burst of
// len words starting at base_addr and streams them out on valid/ready.
// Build option: define RAM_BURST_READER_WRAP_EN to let a burst run past the
// top of the RAM and wrap to address 0; otherwise such requests pulse err.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam int ENTRY_W = fifo_entry_width(DATA_WIDTH);
  localparam int LEN_W   = ADDR_WIDTH + 1;
  localparam int OCC_W   = FIFO_CNT_W + 1;

  // One past the last RAM address, in a width that also holds base+len.
  localparam logic [ADDR_WIDTH+1:0] ADDR_SPAN = {2'b01, {ADDR_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [LEN_W-1:0]      remaining_q, remaining_d;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  issue;
  logic                  last_issue;
  logic                  pop;
  logic                  req_illegal;
  logic [OCC_W-1:0]      occupancy;

  logic [ENTRY_W-1:0]    fifo_head;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  fifo_empty;

`ifdef RAM_BURST_READER_WRAP_EN
  // Any base/length pair is accepted; the address counter wraps naturally.
  assign req_illegal = 1'b0;
`else
  // Reject bursts that would run past the top of the RAM.
  logic [ADDR_WIDTH+1:0] req_end;
  assign req_end     = {2'b00, base_addr} + {1'b0, len};
  assign req_illegal = (req_end > ADDR_SPAN);
`endif

  // Stream side comes straight from the FIFO head.
  assign m_valid = !fifo_empty;
  assign m_data  = fifo_head[DATA_WIDTH-1:0];
  assign m_last  = m_valid && fifo_head[DATA_WIDTH];
  assign pop     = m_valid && m_ready;

  // Words that will sit in the FIFO at the end of this cycle.
  assign occupancy = {1'b0, fifo_count} + OCC_W'(inflight_q) - OCC_W'(pop);

  assign last_issue = issue && (remaining_q == LEN_W'(1));

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign mem_we   = 1'b0;
  assign mem_addr = issue ? rd_addr_q : addr_hold_q;

  // Next-state logic, issue decision and request validation.
  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else if (req_illegal) begin
            err_d = 1'b1;
          end else begin
            rd_addr_d   = base_addr;
            remaining_d = len;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        issue = (occupancy < OCC_W'(FIFO_DEPTH));
        if (issue) begin
          rd_addr_d   = rd_addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && fifo_head[DATA_WIDTH]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, read-pipeline tracking and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      rd_addr_q       <= '0;
      remaining_q     <= '0;
      addr_hold_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_addr_q       <= rd_addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
      done_q          <= done_d;
      err_q           <= err_d;
      if (issue) begin
        addr_hold_q <= rd_addr_q;
      end
    end
  end

  // Read data lands in the FIFO the cycle after its address was driven.
  ram_rd_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({inflight_last_q, mem_rdata}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader: a behavioural RAM plus a queue
// of expected beats computed from base/len, checked under various m_ready
// patterns, boundary lengths, reset mid-burst and ignored start pulses.
module tb_ram_burst_reader;

  localparam int DW    = 8;
  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];

  int checks   = 0;
  int failures = 0;

  ram_burst_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM with registered address: data follows one cycle later.
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Runs one legal burst and checks every beat, stalls, latency and done.
  task automatic run_burst(input int b, input int l, input int mode, input int inject_at);
    int   budget;
    int   first_valid;
    int   last_hs;
    int   done_cyc;
    bit   finished;
    bit   stalled;
    logic [DW:0] held;
    logic rdy;

    exp_q.delete();
    for (int i = 0; i < l; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
    budget      = 4 * l + 20;
    first_valid = -1;
    last_hs     = -10;
    done_cyc    = -1;
    finished    = 1'b0;
    stalled     = 1'b0;
    held        = '0;

    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(b);
    len       = (AW + 1)'(l);
    m_ready   = pick_ready(mode, 0);

    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      start = (cyc == inject_at);
      if (start) begin
        base_addr = AW'(500);
        len       = (AW + 1)'(3);
      end
      if (cyc == 0) begin
        check("busy_rise", busy, 1);
        check("first_addr", mem_addr, b % DEPTH);
        check("mem_we", mem_we, 0);
      end
      if (stalled) check("stall_hold", {m_valid, m_last, m_data}, {1'b1, held});
      if (done) begin
        check("done_timing", cyc, last_hs + 1);
        check("busy_fall", busy, 0);
        check("beats_left", exp_q.size(), 0);
        done_cyc = cyc;
        finished = 1'b1;
        break;
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      rdy     = pick_ready(mode, cyc + 1);
      m_ready = rdy;
      stalled = m_valid && !rdy;
      held    = {m_last, m_data};
      if (m_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          check("beat_data", m_data, exp_q.pop_front());
          check("beat_last", m_last, exp_q.size() == 0);
        end
        last_hs = cyc;
      end
    end
    start = 1'b0;
    if (!finished) check("burst_timeout", 0, 1);
    check("first_valid_latency", first_valid, 2);
    if (mode == 0 && finished) check("done_latency", done_cyc, l + 2);
    @(negedge clk);
    check("done_width", done, 0);
    check("idle_no_valid", m_valid, 0);
    if (inject_at >= 0) begin
      repeat (3) @(negedge clk);
      check("ignored_start_no_burst", {busy, m_valid}, 0);
    end
  endtask

  // Zero-length request: done pulse, nothing else.
  task automatic run_zero_len();
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(7);
    len       = '0;
    @(negedge clk);
    start = 1'b0;
    check("zero_len_done", {done, busy, err, m_valid}, 4'b1000);
    @(negedge clk);
    check("zero_len_after", {done, busy, m_valid}, 0);
  endtask

  // Out-of-range request without wrap support: err pulse, no reads.
  task automatic run_illegal(input int b, input int l);
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(b);
    len       = (AW + 1)'(l);
    @(negedge clk);
    start = 1'b0;
    check("illegal_err", {err, done, busy}, 3'b100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("illegal_quiet", {err, busy, m_valid}, 0);
    end
  endtask

  initial begin
    int hs;
    int b;
    int l;

    for (int i = 0; i < DEPTH; i++) mem[i] = i[7:0];
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_status", {busy, done, err, m_valid, m_last}, 0);
    check("reset_data", m_data, 0);
    check("reset_addr", {mem_we, mem_addr}, 0);
    rst = 1'b0;

    // Directed bursts: full rate, then the 1,0,0,1 stall pattern.
    run_burst(5, 4, 0, -1);
    run_burst(5, 4, 1, -1);

    run_zero_len();

    // Burst crossing the top of the RAM.
`ifdef RAM_BURST_READER_WRAP_EN
    run_burst(2046, 4, 0, -1);
    run_burst(2040, 20, 2, -1);
`else
    run_illegal(2046, 4);
    run_illegal(0, 2049);
`endif
    // Bursts ending exactly at the top are always legal.
    run_burst(2044, 4, 1, -1);

    // Reset mid-burst after two beats, then a fresh burst.
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(100);
    len       = (AW + 1)'(10);
    m_ready   = 1'b1;
    hs        = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_valid && m_ready) begin
        check("pre_reset_beat", m_data, mem[100 + hs]);
        hs++;
      end
      if (hs == 2) begin
        rst = 1'b1;
        break;
      end
    end
    if (hs != 2) check("pre_reset_timeout", hs, 2);
    @(negedge clk);
    check("mid_reset_clear", {m_valid, busy, done, m_last}, 0);
    rst = 1'b0;
    run_burst(0, 2, 0, -1);

    // start pulsed while busy must be ignored.
    run_burst(10, 6, 0, 3);
    run_burst(20, 5, 1, 4);

    // Randomised bursts and m_ready patterns.
    for (int n = 0; n < 8; n++) begin
      l = int'($urandom_range(1, 24));
`ifdef RAM_BURST_READER_WRAP_EN
      b = int'($urandom_range(0, DEPTH - 1));
`else
      b = int'($urandom_range(0, DEPTH - l));
`endif
      run_burst(b, l, 2, -1);
    end

    // Maximum length burst covering the whole RAM.
    run_burst(0, DEPTH, 2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
